pagemem_ctl: RTL

Paged external-memory controller that consumes the `page[4:0]` and `bram_disable` outputs of the page-select register block. It decodes CPU addresses $0000–$BFFF, builds the 19-bit address for the 512 KB external RAM/ROM space, and enforces ROM write lock. It runs a wait-state access sequencer that stalls the CPU through `cpu_ready`. It sits between the CPU bus and the external memory pins, alongside the built-in block RAM.

---
 rtl/p601_mem_pkg.sv | 18 +
 rtl/pagemem_decode.sv | 33 +++
 rtl/pagemem_ctl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/p601_mem_pkg.sv
// Shared types and constants for the paged external-memory controller.
// Holds the access-sequencer state encoding and the CPU address window bounds.
package p601_mem_pkg;

  localparam int EXT_AW = 19;

  localparam logic [15:0] LOW_END   = 16'h7FFF;
  localparam logic [15:0] PAGE_BASE = 16'h8000;
  localparam logic [15:0] PAGE_END  = 16'hBFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/pagemem_decode.sv
// Combinational CPU address decode: built-in RAM select, external RAM/ROM
// select, 19-bit external address build and ROM write-lock detection.
module pagemem_decode
  import p601_mem_pkg::*;
(
  input  logic              i_vma,
  input  logic              i_rw,
  input  logic [15:0]       i_addr,
  input  logic [4:0]        i_page,
  input  logic              i_bram_disable,
  input  logic              i_rom_lock,
  output logic              o_bram_cs,
  output logic              o_ext_req,
  output logic              o_is_rom,
  output logic              o_blocked,
  output logic [EXT_AW-1:0] o_ext_addr
);

  logic w_low;
  logic w_paged;

  assign w_low   = (i_addr <= LOW_END);
  assign w_paged = (i_addr >= PAGE_BASE) && (i_addr <= PAGE_END);

  assign o_bram_cs = i_vma & w_low & ~i_bram_disable;
  assign o_is_rom  = w_paged & i_page[4];
  assign o_blocked = i_vma & o_is_rom & i_rom_lock & ~i_rw;
  assign o_ext_req = i_vma & ((w_low & i_bram_disable) | w_paged) & ~o_blocked;

  // Banks 0/1 land on the same external RAM as the low window; that alias is intended.
  assign o_ext_addr = w_paged ? {i_page, i_addr[13:0]} : {4'b0000, i_addr[14:0]};

endmodule

// File: rtl/pagemem_ctl.sv
// Paged external-memory controller with a wait-state access sequencer.
// Optional sticky blocked-write flag under `PAGEMEM_WRFAULT_EN.
// Handshake: the CPU holds address/data while o_cpu_ready=0 and treats the
// access as complete on the rising edge where o_cpu_ready=1 with i_cpu_vma=1.
module pagemem_ctl #(
  parameter int RAM_WAIT = 1,
  parameter int ROM_WAIT = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [15:0]           i_cpu_addr,
  input  logic [7:0]            i_cpu_di,
  output logic [7:0]            o_cpu_do,
  input  logic                  i_cpu_rw,
  input  logic                  i_cpu_vma,
  output logic                  o_cpu_ready,
  input  logic [4:0]            i_page,
  input  logic                  i_bram_disable,
  input  logic                  i_rom_lock,
  output logic                  o_bram_cs,
  output logic [18:0]           o_ext_addr,
  output logic [7:0]            o_ext_dout,
  output logic                  o_ext_dout_oe,
  input  logic [7:0]            i_ext_din,
  output logic                  o_ext_ram_ce_n,
  output logic                  o_ext_rom_ce_n,
  output logic                  o_ext_oe_n,
  output logic                  o_ext_we_n,
  output logic                  o_wr_fault,
  input  logic                  i_fault_clr,
  output p601_mem_pkg::state_t  o_state
);

  import p601_mem_pkg::*;

  localparam logic [3:0] RAM_CNT = 4'(RAM_WAIT);
  localparam logic [3:0] ROM_CNT = 4'(ROM_WAIT);

  state_t            r_state;
  state_t            w_next;
  logic              w_ready;
  logic [3:0]        r_cnt;
  logic              r_is_rom;
  logic              r_wr;
  logic [EXT_AW-1:0] r_ext_addr;
  logic [7:0]        r_ext_dout;
  logic [7:0]        r_cpu_do;

  logic              w_ext_req;
  logic              w_is_rom;
  logic              w_blocked;
  logic [EXT_AW-1:0] w_dec_addr;
  logic              w_active;

  pagemem_decode u_decode (
    .i_vma          (i_cpu_vma),
    .i_rw           (i_cpu_rw),
    .i_addr         (i_cpu_addr),
    .i_page         (i_page),
    .i_bram_disable (i_bram_disable),
    .i_rom_lock     (i_rom_lock),
    .o_bram_cs      (o_bram_cs),
    .o_ext_req      (w_ext_req),
    .o_is_rom       (w_is_rom),
    .o_blocked      (w_blocked),
    .o_ext_addr     (w_dec_addr)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_ext_req) begin
          w_next  = SETUP;
          w_ready = 1'b0;
        end
      end
      SETUP: begin
        w_next  = STROBE;
        w_ready = 1'b0;
      end
      STROBE: begin
        w_ready = 1'b0;
        if (r_cnt == 4'd0) w_next = HOLD;
      end
      HOLD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bank, lock and select are captured once here, so mid-access changes are ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= 4'd0;
      r_is_rom   <= 1'b0;
      r_wr       <= 1'b0;
      r_ext_addr <= '0;
      r_ext_dout <= 8'h00;
      r_cpu_do   <= 8'h00;
    end else begin
      if (r_state == IDLE && w_ext_req) begin
        r_ext_addr <= w_dec_addr;
        r_ext_dout <= i_cpu_di;
        r_is_rom   <= w_is_rom;
        r_wr       <= ~i_cpu_rw;
        r_cnt      <= w_is_rom ? ROM_CNT : RAM_CNT;
      end else if (r_state == STROBE && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == STROBE && r_cnt == 4'd0 && !r_wr) r_cpu_do <= i_ext_din;
    end
  end

  // Strobes decode straight from state so an async reset releases them at once.
  assign w_active       = (r_state != IDLE);
  assign o_ext_ram_ce_n = ~(w_active & ~r_is_rom);
  assign o_ext_rom_ce_n = ~(w_active & r_is_rom);
  assign o_ext_oe_n     = ~((r_state == STROBE) & ~r_wr);
  assign o_ext_we_n     = ~((r_state == STROBE) & r_wr);
  assign o_ext_dout_oe  = w_active & r_wr;
  assign o_ext_addr     = r_ext_addr;
  assign o_ext_dout     = r_ext_dout;
  assign o_cpu_do       = r_cpu_do;
  assign o_cpu_ready    = w_ready;
  assign o_state        = r_state;

`ifdef PAGEMEM_WRFAULT_EN
  logic r_wr_fault;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                              r_wr_fault <= 1'b0;
    else if (r_state == IDLE && w_blocked)  r_wr_fault <= 1'b1;
    else if (i_fault_clr)                   r_wr_fault <= 1'b0;
  end

  assign o_wr_fault = r_wr_fault;
`else
  logic w_unused_fault;

  assign w_unused_fault = i_fault_clr ^ w_blocked;
  assign o_wr_fault     = 1'b0;
`endif

endmodule
